// File: rtl/alu_div_pkg.sv
// Shared encodings for the iterative RV32M divider.
// Op codes, FSM states and the divide-by-zero quotient constant.
package alu_div_pkg;

   typedef enum logic [1:0] {
      OP_DIV  = 2'b00,
      OP_DIVU = 2'b01,
      OP_REM  = 2'b10,
      OP_REMU = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIX  = 2'b10,
      DONE = 2'b11
   } state_e;

   // Wide enough for any supported WIDTH; users slice the low bits.
   localparam logic [63:0] DIV_ZERO_Q = '1;

endpackage

// File: rtl/alu_divider_step.sv
// One restoring-division step: shift {rem,quo} left, trial-subtract.
// Ports: rem/quo/divisor in, rem_next/quo_next out (combinational).
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic [WIDTH-1:0] quo_next
);

   logic [WIDTH:0] sh;
   logic [WIDTH:0] diff;
   logic           ge;

   assign sh   = {rem, quo[WIDTH-1]};
   assign diff = sh - {1'b0, divisor};

   // rem < divisor on entry, so sh < 2*divisor: a non-negative
   // difference always fits in WIDTH bits and bit WIDTH is the borrow.
   assign ge = ~diff[WIDTH];

   assign rem_next = ge ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
   assign quo_next = {quo[WIDTH-2:0], ge};

endmodule

// File: rtl/alu_divider.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU.
// Ports: clk, rst_n, start/op/A/B request; busy, done, result out.
module alu_divider
   import alu_div_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int CW = $clog2(WIDTH);

   state_e           state, state_n;
   op_e              op_q, op_n;
   logic [WIDTH-1:0] rem_q, rem_n;
   logic [WIDTH-1:0] quo_q, quo_n;
   logic [WIDTH-1:0] dvs_q, dvs_n;
   logic [WIDTH-1:0] res_q, res_n;
   logic             qneg_q, qneg_n;
   logic             rneg_q, rneg_n;
   logic [CW-1:0]    cnt_q, cnt_n;

   logic [WIDTH-1:0] step_rem;
   logic [WIDTH-1:0] step_quo;
   logic             sgn;
   logic             is_rem;
   logic             fix_rem;

   assign sgn     = ~op[0];
   assign is_rem  = op[1];
   assign fix_rem = (op_q == OP_REM) || (op_q == OP_REMU);

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem_q),
      .quo      (quo_q),
      .divisor  (dvs_q),
      .rem_next (step_rem),
      .quo_next (step_quo)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         op_q   <= OP_DIV;
         rem_q  <= '0;
         quo_q  <= '0;
         dvs_q  <= '0;
         res_q  <= '0;
         qneg_q <= 1'b0;
         rneg_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         state  <= state_n;
         op_q   <= op_n;
         rem_q  <= rem_n;
         quo_q  <= quo_n;
         dvs_q  <= dvs_n;
         res_q  <= res_n;
         qneg_q <= qneg_n;
         rneg_q <= rneg_n;
         cnt_q  <= cnt_n;
      end
   end

   always_comb begin
      state_n = state;
      op_n    = op_q;
      rem_n   = rem_q;
      quo_n   = quo_q;
      dvs_n   = dvs_q;
      res_n   = res_q;
      qneg_n  = qneg_q;
      rneg_n  = rneg_q;
      cnt_n   = cnt_q;
      unique case (state)
         IDLE: begin
            if (start) begin
               if (B == '0) begin
                  res_n   = is_rem ? A : DIV_ZERO_Q[WIDTH-1:0];
                  state_n = DONE;
               end else begin
                  op_n    = op_e'(op);
                  // Dividend rides in quo and shifts into rem.
                  quo_n   = (sgn && A[WIDTH-1]) ? -A : A;
                  dvs_n   = (sgn && B[WIDTH-1]) ? -B : B;
                  qneg_n  = sgn & (A[WIDTH-1] ^ B[WIDTH-1]);
                  rneg_n  = sgn & A[WIDTH-1];
                  rem_n   = '0;
                  cnt_n   = CW'(WIDTH - 1);
                  state_n = CALC;
               end
            end
         end
         CALC: begin
            rem_n = step_rem;
            quo_n = step_quo;
            if (cnt_q == '0) begin
               state_n = FIX;
            end else begin
               cnt_n = cnt_q - 1'b1;
            end
         end
         FIX: begin
            if (fix_rem) begin
               res_n = rneg_q ? -rem_q : rem_q;
            end else begin
               res_n = qneg_q ? -quo_q : quo_q;
            end
            state_n = DONE;
         end
         DONE: begin
            state_n = IDLE;
         end
      endcase
   end

   assign busy   = (state != IDLE);
   assign done   = (state == DONE);
   assign result = res_q;

endmodule
